// File: rtl/qam_mapper_pkg.sv
// Shared types and helpers for the QAM symbol mapper: mode enum, bits-per-symbol,
// Gray-to-odd-level decoders and the scale multipliers (Q16) applied to AMP.
package qam_pkg;

  typedef enum logic [1:0] {
    BPSK  = 2'd0,
    QPSK  = 2'd1,
    QAM16 = 2'd2,
    QAM64 = 2'd3
  } syb_mode_t;

  // Q16 multipliers: 1/sqrt(2), 1/sqrt(18), 1/sqrt(98) relative to the BPSK peak
  localparam int MUL_LQ = 46341;
  localparam int MUL_16 = 15447;
  localparam int MUL_64 = 6620;

  function automatic logic [2:0] bits_per_sym(syb_mode_t m);
    case (m)
      BPSK:    return 3'd1;
      QPSK:    return 3'd2;
      QAM16:   return 3'd4;
      default: return 3'd6;
    endcase
  endfunction

  function automatic logic signed [3:0] gray2_odd(logic [1:0] g);
    case (g)
      2'b00:   return -4'sd3;
      2'b01:   return -4'sd1;
      2'b11:   return  4'sd1;
      default: return  4'sd3;
    endcase
  endfunction

  function automatic logic signed [3:0] gray3_odd(logic [2:0] g);
    case (g)
      3'b000:  return -4'sd7;
      3'b001:  return -4'sd5;
      3'b011:  return -4'sd3;
      3'b010:  return -4'sd1;
      3'b110:  return  4'sd1;
      3'b111:  return  4'sd3;
      3'b101:  return  4'sd5;
      default: return  4'sd7;
    endcase
  endfunction

endpackage

// File: rtl/qam_mapper_if.sv
// Bit-stream input and mapped I/Q output bundle of the QAM mapper.
interface qam_mapper_if #(parameter int OUT_W = 16);
  logic                    bit_in;
  logic                    bit_vld;
  logic [1:0]              syb;
  logic signed [OUT_W-1:0] i;
  logic signed [OUT_W-1:0] q;
  logic                    cke;
  logic                    den;

  modport master (output bit_in, bit_vld, syb, input i, q, cke, den);
  modport slave  (input bit_in, bit_vld, syb, output i, q, cke, den);
endinterface

// File: rtl/qam_mapper_level_lut.sv
// Combinational constellation lookup: symbol bits -> unscaled odd-integer I/Q levels.
module qam_level_lut
  import qam_pkg::*;
(
  input  syb_mode_t          mode,
  input  logic [5:0]         sym,
  output logic signed [3:0]  lvl_i,
  output logic signed [3:0]  lvl_q
);

  always_comb begin
    lvl_i = '0;
    lvl_q = '0;
    case (mode)
      BPSK: begin
        lvl_i = sym[0] ? -4'sd1 : 4'sd1;
      end
      QPSK: begin
        lvl_i = sym[1] ? -4'sd1 : 4'sd1;
        lvl_q = sym[0] ? -4'sd1 : 4'sd1;
      end
      QAM16: begin
        lvl_i = gray2_odd(sym[3:2]);
        lvl_q = gray2_odd(sym[1:0]);
      end
      default: begin
        lvl_i = gray3_odd(sym[5:3]);
        lvl_q = gray3_odd(sym[2:0]);
      end
    endcase
  end

endmodule

// File: rtl/qam_mapper.sv
// Serial-bit to BPSK/QPSK/16QAM/64QAM symbol mapper with cke/den strobes.
// Optional differential encoding for BPSK/QPSK under QAM_MAPPER_DIFF_ENC_EN.
module qam_mapper
  import qam_pkg::*;
#(
  parameter int AMP   = 16384,
  parameter int OUT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  qam_mapper_if.slave bus
);

  localparam int LQ  = int'((longint'(AMP) * MUL_LQ) >> 16);
  localparam int S16 = int'((longint'(AMP) * MUL_16) >> 16);
  localparam int S64 = int'((longint'(AMP) * MUL_64) >> 16);

  syb_mode_t               syb_m, mode_q, mode_d;
  logic [2:0]              k, cnt_b, cnt_q, cnt_d;
  logic [4:0]              sr_q, sr_d;
  logic [5:0]              sym, sym_map;
  logic signed [OUT_W-1:0] lvl_i_q, lvl_i_d, lvl_q_q, lvl_q_d;
  logic                    cke_q, cke_d, den_q, den_d;
  logic                    chg, done;
  logic signed [3:0]       lut_i, lut_q;
  logic signed [23:0]      scale, prod_i, prod_q;

  // A mode change restarts everything; the current bit is then taken as bit 0 of the new mode.
  always_comb begin
    syb_m  = syb_mode_t'(bus.syb);
    chg    = (syb_m != mode_q);
    mode_d = syb_m;
    k      = bits_per_sym(syb_m);
    cnt_b  = chg ? 3'd0 : cnt_q;
    sym    = {(chg ? 5'd0 : sr_q), bus.bit_in};
    done   = bus.bit_vld && (cnt_b == k - 3'd1);
  end

`ifdef QAM_MAPPER_DIFF_ENC_EN
  logic dpi_q, dpi_d, dpq_q, dpq_d, dpi_b, dpq_b;

  always_comb begin
    dpi_b   = chg ? 1'b0 : dpi_q;
    dpq_b   = chg ? 1'b0 : dpq_q;
    sym_map = sym;
    dpi_d   = dpi_b;
    dpq_d   = dpq_b;
    case (syb_m)
      BPSK: begin
        sym_map[0] = sym[0] ^ dpi_b;
        if (done) dpi_d = sym_map[0];
      end
      QPSK: begin
        sym_map[1] = sym[1] ^ dpi_b;
        sym_map[0] = sym[0] ^ dpq_b;
        if (done) begin
          dpi_d = sym_map[1];
          dpq_d = sym_map[0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dpi_q <= 1'b0;
      dpq_q <= 1'b0;
    end else begin
      dpi_q <= dpi_d;
      dpq_q <= dpq_d;
    end
  end
`else
  assign sym_map = sym;
`endif

  qam_level_lut u_lut (
    .mode  (syb_m),
    .sym   (sym_map),
    .lvl_i (lut_i),
    .lvl_q (lut_q)
  );

  always_comb begin
    case (syb_m)
      BPSK:    scale = 24'(AMP);
      QPSK:    scale = 24'(LQ);
      QAM16:   scale = 24'(S16);
      default: scale = 24'(S64);
    endcase
    prod_i = $signed({{20{lut_i[3]}}, lut_i}) * scale;
    prod_q = $signed({{20{lut_q[3]}}, lut_q}) * scale;
  end

  always_comb begin
    cnt_d   = cnt_b;
    sr_d    = chg ? 5'd0 : sr_q;
    lvl_i_d = chg ? '0 : lvl_i_q;
    lvl_q_d = chg ? '0 : lvl_q_q;
    den_d   = chg ? 1'b0 : den_q;
    cke_d   = 1'b0;
    if (bus.bit_vld) begin
      sr_d  = sym[4:0];
      cnt_d = done ? 3'd0 : cnt_b + 3'd1;
    end
    if (done) begin
      lvl_i_d = OUT_W'(prod_i);
      lvl_q_d = OUT_W'(prod_q);
      cke_d   = 1'b1;
      den_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q  <= syb_m;
      cnt_q   <= '0;
      sr_q    <= '0;
      lvl_i_q <= '0;
      lvl_q_q <= '0;
      cke_q   <= 1'b0;
      den_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      lvl_i_q <= lvl_i_d;
      lvl_q_q <= lvl_q_d;
      cke_q   <= cke_d;
      den_q   <= den_d;
    end
  end

  assign bus.i   = lvl_i_q;
  assign bus.q   = lvl_q_q;
  assign bus.cke = cke_q;
  assign bus.den = den_q;

endmodule

// File: tb/tb_qam_mapper.sv
// Directed bench for qam_mapper: hand-computed I/Q levels and strobe timing.
module tb_qam_mapper;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  qam_mapper_if #(.OUT_W(16)) bus ();

  qam_mapper #(.AMP(16384), .OUT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int ei, input int eq, input int ecke, input int eden);
    chk({tag, ".i"},   $signed(bus.i), ei);
    chk({tag, ".q"},   $signed(bus.q), eq);
    chk({tag, ".cke"}, {31'd0, bus.cke}, ecke);
    chk({tag, ".den"}, {31'd0, bus.den}, eden);
  endtask

  task automatic send(input logic b);
    bus.bit_in  = b;
    bus.bit_vld = 1'b1;
    tick();
    bus.bit_vld = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    bus.syb     = m;
    bus.bit_vld = 1'b0;
    tick();
  endtask

  int exp2 [4];
  int exp6 [4];
  logic b2 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic b6 [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
`ifdef QAM_MAPPER_DIFF_ENC_EN
    exp2 = '{16384, -16384, 16384, 16384};
    exp6 = '{-16384, 16384, 16384, -16384};
`else
    exp2 = '{16384, -16384, -16384, 16384};
    exp6 = '{-16384, -16384, 16384, -16384};
`endif
    rst         = 1'b0;
    bus.syb     = 2'd2;
    bus.bit_in  = 1'b1;
    bus.bit_vld = 1'b0;

    // reset held while strobing bits
    for (int c = 0; c < 3; c++) begin
      bus.bit_vld = (c % 2 == 0);
      tick();
      chk_out("reset", 0, 0, 0, 0);
    end
    bus.bit_vld = 1'b0;
    rst = 1'b1;

    // 16QAM, strobe every 3rd cycle: 1,0,0,1 -> +3*3861, -1*3861
    send(1'b1); tick(); tick(); chk_out("q16_b1", 0, 0, 0, 0);
    send(1'b0); tick(); tick(); chk_out("q16_b2", 0, 0, 0, 0);
    send(1'b0); tick(); tick(); chk_out("q16_b3", 0, 0, 0, 0);
    send(1'b1);
    chk_out("q16_sym", 11583, -3861, 1, 1);
    tick();
    chk_out("q16_hold", 11583, -3861, 0, 1);

    // BPSK at full rate
    set_mode(2'd0);
    chk_out("to_bpsk", 0, 0, 0, 0);
    for (int n = 0; n < 4; n++) begin
      bus.bit_in  = b2[n];
      bus.bit_vld = 1'b1;
      tick();
      chk_out($sformatf("bpsk%0d", n), exp2[n], 0, 1, 1);
    end
    bus.bit_vld = 1'b0;
    tick();
    chk_out("bpsk_idle", exp2[3], 0, 0, 1);

    // 64QAM 100 011 -> +7*1655, -3*1655
    set_mode(2'd3);
    send(1'b1); send(1'b0); send(1'b0); send(1'b0); send(1'b1);
    chk_out("q64_part", 0, 0, 0, 0);
    send(1'b1);
    chk_out("q64_sym", 11585, -4965, 1, 1);
    // partial 64QAM symbol abandoned by switch to QPSK
    send(1'b1); send(1'b1); send(1'b1);
    chk_out("q64_part2", 11585, -4965, 0, 1);
    set_mode(2'd1);
    chk_out("to_qpsk", 0, 0, 0, 0);
    send(1'b0);
    chk_out("qpsk_b1", 0, 0, 0, 0);
    send(1'b1);
    chk_out("qpsk_sym", 11585, -11585, 1, 1);

    // mode change 2->0 concurrent with a strobe
    set_mode(2'd2);
    send(1'b1); send(1'b1);
    bus.syb     = 2'd0;
    bus.bit_in  = 1'b1;
    bus.bit_vld = 1'b1;
    tick();
    bus.bit_vld = 1'b0;
    chk_out("chg_bpsk", -16384, 0, 1, 1);

    // BPSK 1,1,0,1 starting from a cleared differential state
    set_mode(2'd1);
    set_mode(2'd0);
    for (int n = 0; n < 4; n++) begin
      send(b6[n]);
      chk_out($sformatf("diff%0d", n), exp6[n], 0, 1, 1);
    end

    // reset mid-symbol drops the partial bits
    set_mode(2'd2);
    send(1'b1); send(1'b1);
    rst = 1'b0;
    tick();
    chk_out("mid_rst", 0, 0, 0, 0);
    rst = 1'b1;
    send(1'b0); send(1'b0);
    chk_out("post_rst_part", 0, 0, 0, 0);
    send(1'b1); send(1'b1);
    chk_out("post_rst_sym", -11583, 3861, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
